// File: rtl/msg_loc_queue.sv
// msg_loc_queue: captures {start,end} buffer addresses of framed messages
// into a circular table. Entries are popped in arrival order through a
// valid/ready port. Handles aborted messages, drops messages that arrive
// while the table is full, and keeps a saturating drop counter.
module msg_loc_queue #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DEPTH          = 8,
  parameter int DROP_CNT_WIDTH = 8,
  localparam int PTR_W         = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_message_i,
  input  logic [ADDR_WIDTH-1:0]     start_addr_i,
  input  logic                      end_message_i,
  input  logic [ADDR_WIDTH-1:0]     end_addr_i,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ADDR_WIDTH-1:0]     out_start_o,
  output logic [ADDR_WIDTH-1:0]     out_end_o,
  output logic [ADDR_WIDTH-1:0]     out_len_o,
  output logic [PTR_W:0]            count_o,
  output logic                      full_o,
  output logic                      aborted_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  localparam logic [PTR_W:0] DEPTH_C  = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] DEPTH_M1 = DEPTH_C - 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DROP} state_t;

  state_t                      state_reg, state_next;
  logic [ADDR_WIDTH-1:0]       pend_reg, pend_next;
  logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]              count_reg;
  logic                        aborted_reg, abort_next;
  logic [DROP_CNT_WIDTH-1:0]   drop_cnt_reg;
  logic [2*ADDR_WIDTH-1:0]     tbl_mem [DEPTH];

  logic                        commit;
  logic [ADDR_WIDTH-1:0]       commit_start;
  logic                        drop_inc;
  logic                        pop;
  logic                        space;
  logic                        space_after_commit;

  // Space is judged on the registered count, so a same-cycle pop never
  // makes room for a message arriving while the table is full.
  assign space              = (count_reg < DEPTH_C);
  assign space_after_commit = (count_reg < DEPTH_M1);

  assign out_valid_o = (count_reg != '0);
  assign pop         = out_valid_o & out_ready_i;
  assign out_start_o = tbl_mem[rd_ptr_reg][2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign out_end_o   = tbl_mem[rd_ptr_reg][ADDR_WIDTH-1:0];
  // Modular subtraction copes with messages that wrap the byte buffer.
  assign out_len_o   = out_end_o - out_start_o + 1'b1;
  assign count_o     = count_reg;
  assign full_o      = (count_reg == DEPTH_C);
  assign aborted_o   = aborted_reg;
  assign drop_cnt_o  = drop_cnt_reg;

  // Capture FSM: decide commit / drop / abort and the next state.
  always_comb begin
    state_next   = state_reg;
    pend_next    = pend_reg;
    commit       = 1'b0;
    commit_start = start_addr_i;
    drop_inc     = 1'b0;
    abort_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_message_i && end_message_i) begin
          if (space) commit = 1'b1;
          else       drop_inc = 1'b1;
        end else if (start_message_i) begin
          if (space) begin
            pend_next  = start_addr_i;
            state_next = S_OPEN;
          end else begin
            state_next = S_DROP;
          end
        end
      end
      S_OPEN: begin
        if (end_message_i) begin
          commit       = 1'b1;
          commit_start = pend_reg;
          if (start_message_i) begin
            // The new start sees the table as it will be after this commit.
            pend_next  = start_addr_i;
            state_next = space_after_commit ? S_OPEN : S_DROP;
          end else begin
            state_next = S_IDLE;
          end
        end else if (start_message_i) begin
          abort_next = 1'b1;
          pend_next  = start_addr_i;
        end
      end
      S_DROP: begin
        if (end_message_i) begin
          drop_inc = 1'b1;
          if (start_message_i) begin
            if (space) begin
              pend_next  = start_addr_i;
              state_next = S_OPEN;
            end else begin
              state_next = S_DROP;
            end
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state, pointers, occupancy and counters; flush beats everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      pend_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      aborted_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (flush_i) begin
      state_reg   <= S_IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      aborted_reg <= abort_next;
      if (commit) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({commit, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop_inc && (drop_cnt_reg != {DROP_CNT_WIDTH{1'b1}}))
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  // Table storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (commit && !flush_i && !rst)
      tbl_mem[wr_ptr_reg] <= {commit_start, end_addr_i};
  end

endmodule

// File: tb/tb_msg_loc_queue.sv
// Bench for msg_loc_queue: scoreboard of expected {start,end} entries,
// compared as the DUT presents them on its pop port.
module tb_msg_loc_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_message_i;
  logic [4:0] start_addr_i;
  logic       end_message_i;
  logic [4:0] end_addr_i;
  logic       flush_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [4:0] out_start_o;
  logic [4:0] out_end_o;
  logic [4:0] out_len_o;
  logic [3:0] count_o;
  logic       full_o;
  logic       aborted_o;
  logic [7:0] drop_cnt_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] sb[$];
  logic [7:0] exp_drop = 8'd0;

  msg_loc_queue #(.ADDR_WIDTH(5), .DEPTH(8), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .start_message_i(start_message_i), .start_addr_i(start_addr_i),
    .end_message_i(end_message_i), .end_addr_i(end_addr_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_start_o(out_start_o), .out_end_o(out_end_o), .out_len_o(out_len_o),
    .count_o(count_o), .full_o(full_o), .aborted_o(aborted_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic step(input logic s, input logic [4:0] sa, input logic e,
                      input logic [4:0] ea, input logic rdy, input logic fl);
    start_message_i = s;  start_addr_i = sa;
    end_message_i   = e;  end_addr_i   = ea;
    out_ready_i     = rdy; flush_i     = fl;
    @(posedge clk); #1;
    start_message_i = 1'b0; end_message_i = 1'b0;
    out_ready_i     = 1'b0; flush_i       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_message_i = 0; start_addr_i = 0; end_message_i = 0; end_addr_i = 0;
    flush_i = 0; out_ready_i = 0;
    #3;
    n_cmp++;
    if ({out_valid_o, count_o, full_o, aborted_o, drop_cnt_o} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b count=%0d full=%b abort=%b drop=%0d want all 0",
               out_valid_o, count_o, full_o, aborted_o, drop_cnt_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [9:0] e; logic [4:0] el;
    step(1, 5'd3, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5'd17, 0, 0); sb.push_back({5'd3, 5'd17});
    n_cmp++;
    if (!out_valid_o || out_len_o !== 5'd15 || count_o !== 4'd1) begin
      n_bad++;
      $display("FAIL basic_commit: valid=%b len=%0d count=%0d want 1/15/1", out_valid_o, out_len_o, count_o);
    end
    e = sb.pop_front(); el = e[4:0] - e[9:5] + 5'd1;
    n_cmp++;
    if (!out_valid_o || {out_start_o, out_end_o} !== e || out_len_o !== el) begin
      n_bad++;
      $display("FAIL basic_pop: got %0d..%0d len %0d want %0d..%0d len %0d", out_start_o, out_end_o, out_len_o, e[9:5], e[4:0], el);
    end
    step(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (out_valid_o !== 1'b0 || count_o !== 4'd0) begin
      n_bad++;
      $display("FAIL basic_empty: valid=%b count=%0d want 0/0", out_valid_o, count_o);
    end
    $display("test_basic done");
  endtask

  task automatic test_wrap_len();
    logic [9:0] e; logic [4:0] el;
    step(1, 5'd28, 0, 0, 0, 0);
    step(0, 0, 1, 5'd4, 0, 0); sb.push_back({5'd28, 5'd4});
    n_cmp++;
    if (out_len_o !== 5'd9) begin
      n_bad++; $display("FAIL wrap_len: got %0d want 9", out_len_o);
    end
    step(1, 5'd7, 1, 5'd7, 0, 0); sb.push_back({5'd7, 5'd7});
    n_cmp++;
    if (count_o !== 4'd2) begin
      n_bad++; $display("FAIL same_cycle_count: got %0d want 2", count_o);
    end
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); el = e[4:0] - e[9:5] + 5'd1;
      n_cmp++;
      if (!out_valid_o || {out_start_o, out_end_o} !== e || out_len_o !== el) begin
        n_bad++;
        $display("FAIL wrap_pop%0d: got %0d..%0d len %0d want %0d..%0d len %0d", i, out_start_o, out_end_o, out_len_o, e[9:5], e[4:0], el);
      end
      step(0, 0, 0, 0, 1, 0);
    end
    $display("test_wrap_len done");
  endtask

  task automatic test_full();
    logic [9:0] e; logic [4:0] el;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(1, 5'(i + r * 8), 1, 5'(i + 10 + r * 3), 0, 0);
        sb.push_back({5'(i + r * 8), 5'(i + 10 + r * 3)});
      end
      n_cmp++;
      if (full_o !== 1'b1 || count_o !== 4'd8) begin
        n_bad++; $display("FAIL full_flag r%0d: full=%b count=%0d want 1/8", r, full_o, count_o);
      end
      if (r == 0) begin
        step(1, 5'd1, 0, 0, 0, 0);
        step(0, 0, 1, 5'd2, 0, 0); exp_drop++;
        n_cmp++;
        if (drop_cnt_o !== exp_drop || count_o !== 4'd8) begin
          n_bad++; $display("FAIL full_drop: drop=%0d count=%0d want %0d/8", drop_cnt_o, count_o, exp_drop);
        end
        // start&end at full with a same-cycle pop: pop frees no space.
        e = sb.pop_front(); el = e[4:0] - e[9:5] + 5'd1;
        n_cmp++;
        if (!out_valid_o || {out_start_o, out_end_o} !== e || out_len_o !== el) begin
          n_bad++; $display("FAIL full_pop_head: got %0d..%0d want %0d..%0d", out_start_o, out_end_o, e[9:5], e[4:0]);
        end
        step(1, 5'd20, 1, 5'd21, 1, 0); exp_drop++;
        n_cmp++;
        if (drop_cnt_o !== exp_drop || count_o !== 4'd7) begin
          n_bad++; $display("FAIL full_pop_drop: drop=%0d count=%0d want %0d/7", drop_cnt_o, count_o, exp_drop);
        end
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); el = e[4:0] - e[9:5] + 5'd1;
        n_cmp++;
        if (!out_valid_o || {out_start_o, out_end_o} !== e || out_len_o !== el) begin
          n_bad++;
          $display("FAIL full_order r%0d: got %0d..%0d len %0d want %0d..%0d len %0d", r, out_start_o, out_end_o, out_len_o, e[9:5], e[4:0], el);
        end
        step(0, 0, 0, 0, 1, 0);
      end
      n_cmp++;
      if (count_o !== 4'd0 || out_valid_o !== 1'b0) begin
        n_bad++; $display("FAIL full_drain r%0d: count=%0d valid=%b want 0/0", r, count_o, out_valid_o);
      end
    end
    $display("test_full done");
  endtask

  task automatic test_abort();
    logic [9:0] e;
    step(1, 5'd5, 0, 0, 0, 0);
    step(1, 5'd9, 0, 0, 0, 0);
    n_cmp++;
    if (aborted_o !== 1'b1) begin n_bad++; $display("FAIL abort_pulse: got %b want 1", aborted_o); end
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (aborted_o !== 1'b0) begin n_bad++; $display("FAIL abort_clear: got %b want 0", aborted_o); end
    step(0, 0, 1, 5'd12, 0, 0); sb.push_back({5'd9, 5'd12});
    n_cmp++;
    if (count_o !== 4'd1) begin n_bad++; $display("FAIL abort_count: got %0d want 1", count_o); end
    e = sb.pop_front();
    n_cmp++;
    if (!out_valid_o || {out_start_o, out_end_o} !== e || out_len_o !== 5'd4) begin
      n_bad++; $display("FAIL abort_entry: got %0d..%0d len %0d want 9..12 len 4", out_start_o, out_end_o, out_len_o);
    end
    step(0, 0, 0, 0, 1, 0);
    $display("test_abort done");
  endtask

  task automatic test_back_to_back();
    logic [9:0] e; logic [4:0] el;
    for (int i = 0; i < 7; i++) begin
      step(1, 5'(2 * i), 1, 5'(2 * i + 1), 0, 0);
      sb.push_back({5'(2 * i), 5'(2 * i + 1)});
    end
    step(1, 5'd20, 0, 0, 0, 0);
    // End in OPEN with a coinciding pop: one in, one out.
    e = sb.pop_front(); el = e[4:0] - e[9:5] + 5'd1;
    n_cmp++;
    if (!out_valid_o || {out_start_o, out_end_o} !== e || out_len_o !== el) begin
      n_bad++; $display("FAIL b2b_pop: got %0d..%0d want %0d..%0d", out_start_o, out_end_o, e[9:5], e[4:0]);
    end
    step(0, 0, 1, 5'd21, 1, 0); sb.push_back({5'd20, 5'd21});
    n_cmp++;
    if (count_o !== 4'd7) begin n_bad++; $display("FAIL b2b_count: got %0d want 7", count_o); end
    step(1, 5'd22, 0, 0, 0, 0);
    step(1, 5'd23, 1, 5'd24, 0, 0); sb.push_back({5'd22, 5'd24});
    n_cmp++;
    if (count_o !== 4'd8 || full_o !== 1'b1) begin
      n_bad++; $display("FAIL b2b_fill: count=%0d full=%b want 8/1", count_o, full_o);
    end
    step(0, 0, 1, 5'd25, 0, 0); exp_drop++;
    n_cmp++;
    if (drop_cnt_o !== exp_drop || count_o !== 4'd8) begin
      n_bad++; $display("FAIL b2b_drop: drop=%0d count=%0d want %0d/8", drop_cnt_o, count_o, exp_drop);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); el = e[4:0] - e[9:5] + 5'd1;
      n_cmp++;
      if (!out_valid_o || {out_start_o, out_end_o} !== e || out_len_o !== el) begin
        n_bad++; $display("FAIL b2b_order: got %0d..%0d len %0d want %0d..%0d len %0d", out_start_o, out_end_o, out_len_o, e[9:5], e[4:0], el);
      end
      step(0, 0, 0, 0, 1, 0);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) step(1, 5'(i), 1, 5'(i + 4), 0, 0);
    step(1, 5'd10, 0, 0, 0, 0);
    step(0, 0, 1, 5'd11, 0, 1);
    n_cmp++;
    if (count_o !== 4'd0 || out_valid_o !== 1'b0 || aborted_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_clear: count=%0d valid=%b abort=%b want 0/0/0", count_o, out_valid_o, aborted_o);
    end
    step(0, 0, 1, 5'd11, 0, 0);
    n_cmp++;
    if (count_o !== 4'd0 || drop_cnt_o !== exp_drop) begin
      n_bad++; $display("FAIL flush_end_ignored: count=%0d drop=%0d want 0/%0d", count_o, drop_cnt_o, exp_drop);
    end
    step(1, 5'd1, 1, 5'd2, 0, 0);
    step(1, 5'd3, 1, 5'd4, 0, 0);
    step(1, 5'd5, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid_o, count_o, full_o, aborted_o, drop_cnt_o} !== 15'd0) begin
      n_bad++; $display("FAIL async_reset: valid=%b count=%0d full=%b abort=%b drop=%0d want all 0",
                        out_valid_o, count_o, full_o, aborted_o, drop_cnt_o);
    end
    exp_drop = 8'd0;
    @(posedge clk); #1; rst = 1'b0;
    step(0, 0, 1, 5'd9, 0, 0);
    step(1, 5'd2, 1, 5'd6, 0, 0);
    n_cmp++;
    if (count_o !== 4'd1 || out_start_o !== 5'd2 || out_end_o !== 5'd6 || out_len_o !== 5'd5) begin
      n_bad++; $display("FAIL post_reset: count=%0d entry %0d..%0d len %0d want 1 2..6 len 5", count_o, out_start_o, out_end_o, out_len_o);
    end
    $display("test_flush_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_len();
    test_full();
    test_abort();
    test_back_to_back();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
